// File: rtl/logic_unit_acc_if.sv
// Operand/result handshake bundle for logic_unit_acc.
// master drives operands and out_ready; slave returns the registered result and status.
interface logic_unit_acc_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_mode;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;
    logic [CNT_W-1:0] count;
    logic             count_sat;

    modport master (
        output in_valid, a, b, op, acc_mode, clear, out_ready,
        input  in_ready, out_valid, result, zero, parity, count, count_sat
    );

    modport slave (
        input  in_valid, a, b, op, acc_mode, clear, out_ready,
        output in_ready, out_valid, result, zero, parity, count, count_sat
    );
endinterface

// File: rtl/logic_unit_acc.sv
// Bitwise logic unit with optional accumulator and saturating op counter.
// Latency: 1 cycle, result/zero/parity registered on the transfer edge.
// Backpressure: single result register; in_ready drops while a held result is not consumed.
module logic_unit_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    logic_unit_acc_if.slave bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             parity_q,    parity_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             count_sat_q, count_sat_d;

    logic             in_ready_c;
    logic             xfer;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] func_out;

    // op[2]=0 keeps the legacy 2-bit key: OR, NOR, XOR, XNOR.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = x | y;
            3'b001:  r = ~(x | y);
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x ^ y);
            3'b100:  r = x & y;
            3'b101:  r = ~(x & y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    assign in_ready_c = ((state_q == EMPTY) || bus.out_ready) && !rst;
    assign xfer       = bus.in_valid && in_ready_c;

    // A clear in the same cycle as an accumulate op starts that op from zero.
    assign acc_base = bus.clear ? '0 : acc_q;
    assign op_x     = bus.acc_mode ? acc_base : bus.a;
    assign op_y     = bus.acc_mode ? bus.a    : bus.b;
    assign func_out = logic_op(bus.op, op_x, op_y);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        count_d     = count_q;
        count_sat_d = count_sat_q;

        if (bus.clear) begin
            acc_d   = '0;
            count_d = '0;
        end

        if (xfer) begin
            state_d  = FULL;
            result_d = func_out;
            zero_d   = (func_out == '0);
            parity_d = ^func_out;
            if (bus.acc_mode) begin
                acc_d = func_out;
                if (bus.clear) begin
                    count_d = CNT_ONE;
                end else if (count_q != CNT_MAX) begin
                    count_d = count_q + CNT_ONE;
                end
            end
        end else if (state_q == FULL && bus.out_ready) begin
            state_d = EMPTY;
        end

        count_sat_d = (count_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            count_q     <= '0;
            count_sat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            count_q     <= count_d;
            count_sat_q <= count_sat_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == FULL);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.count     = count_q;
    assign bus.count_sat = count_sat_q;
endmodule

// File: tb/tb_logic_unit_acc.sv
// Directed bench for logic_unit_acc (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_logic_unit_acc;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic_unit_acc_if #(.WIDTH(8), .CNT_W(4)) bus ();

    logic_unit_acc #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic mode, input logic clr);
        bus.in_valid = vld;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.acc_mode = mode;
        bus.clear    = clr;
    endtask

    logic [2:0] ss_op  [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
    logic [7:0] ss_exp [4] = '{8'hAF, 8'h50, 8'hAA, 8'h55};
    logic [7:0] acc_a  [3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0] acc_exp[3] = '{8'h01, 8'h03, 8'h07};

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        step();
        check("in_ready_in_rst", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid",   32'(bus.out_valid), 32'd0);
        check("rst_result",      32'(bus.result), 32'h00);
        check("rst_zero",        32'(bus.zero), 32'd0);
        check("rst_parity",      32'(bus.parity), 32'd0);
        check("rst_count",       32'(bus.count), 32'd0);
        check("rst_count_sat",   32'(bus.count_sat), 32'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        // Single-shot legacy ops on a=A5, b=0F.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ss_op[i], 8'hA5, 8'h0F, 1'b0, 1'b0);
            step();
            check($sformatf("ss_op%0d_result", i), 32'(bus.result), 32'(ss_exp[i]));
            check($sformatf("ss_op%0d_valid", i), 32'(bus.out_valid), 32'd1);
        end
        check("ss_count_untouched", 32'(bus.count), 32'd0);

        drive(1'b1, 3'b100, 8'hF0, 8'h0F, 1'b0, 1'b0);
        step();
        check("and_result", 32'(bus.result), 32'h00);
        check("and_zero",   32'(bus.zero), 32'd1);
        check("and_parity", 32'(bus.parity), 32'd0);
        drive(1'b1, 3'b101, 8'hF0, 8'h0F, 1'b0, 1'b0);
        step();
        check("nand_result", 32'(bus.result), 32'hFF);
        check("nand_zero",   32'(bus.zero), 32'd0);
        check("nand_parity", 32'(bus.parity), 32'd0);
        drive(1'b1, 3'b110, 8'hA5, 8'h00, 1'b0, 1'b0);
        step();
        check("not_result", 32'(bus.result), 32'h5A);
        drive(1'b1, 3'b111, 8'h07, 8'hFF, 1'b0, 1'b0);
        step();
        check("pass_result", 32'(bus.result), 32'h07);
        check("pass_parity", 32'(bus.parity), 32'd1);

        // Clear alone leaves the held result and out_valid alone.
        bus.out_ready = 1'b0;
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        check("clr_out_valid", 32'(bus.out_valid), 32'd1);
        check("clr_result",    32'(bus.result), 32'h07);
        check("clr_count",     32'(bus.count), 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b010, acc_a[i], 8'hEE, 1'b1, 1'b0);
            step();
            check($sformatf("acc_xor%0d_result", i), 32'(bus.result), 32'(acc_exp[i]));
        end
        check("acc_count3", 32'(bus.count), 32'd3);

        // Backpressure with one held result.
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        drive(1'b1, 3'b111, 8'h11, 8'h00, 1'b0, 1'b0);
        step();
        check("bp_first_result", 32'(bus.result), 32'h11);
        drive(1'b1, 3'b111, 8'h22, 8'h00, 1'b0, 1'b0);
        #1;
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        step();
        check("bp_result_held", 32'(bus.result), 32'h11);
        check("bp_valid_held",  32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_second_result", 32'(bus.result), 32'h22);
        check("bp_second_valid",  32'(bus.out_valid), 32'd1);

        // acc is 07 here; OR in F8 to reach FF, then clear with a concurrent accumulate.
        drive(1'b1, 3'b000, 8'hF8, 8'h00, 1'b1, 1'b0);
        step();
        check("acc_ff_result", 32'(bus.result), 32'hFF);
        check("acc_ff_count",  32'(bus.count), 32'd4);
        drive(1'b1, 3'b000, 8'h10, 8'h00, 1'b1, 1'b1);
        step();
        check("clr_acc_result", 32'(bus.result), 32'h10);
        check("clr_acc_count",  32'(bus.count), 32'd1);

        // Saturation over 17 accumulate transfers.
        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b1);
        step();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 3'b010, 8'h01, 8'h00, 1'b1, 1'b0);
            step();
            if (i == 14) begin
                check("sat_count14", 32'(bus.count), 32'd14);
                check("sat_flag14",  32'(bus.count_sat), 32'd0);
            end
            if (i == 15) check("sat_flag15", 32'(bus.count_sat), 32'd1);
        end
        check("sat_count17",  32'(bus.count), 32'd15);
        check("sat_flag17",   32'(bus.count_sat), 32'd1);
        check("sat_result17", 32'(bus.result), 32'h01);

        // Reset mid-stream with a pending result and a transfer offered.
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(bus.in_ready), 32'd0);
        step();
        rst = 1'b0;
        check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid_result",    32'(bus.result), 32'h00);
        check("rst_mid_count",     32'(bus.count), 32'd0);
        check("rst_mid_count_sat", 32'(bus.count_sat), 32'd0);
        check("rst_mid_parity",    32'(bus.parity), 32'd0);

        // PASS in accumulate mode exposes the accumulator.
        bus.out_ready = 1'b1;
        drive(1'b1, 3'b111, 8'h5A, 8'h00, 1'b1, 1'b0);
        step();
        check("rst_mid_acc",   32'(bus.result), 32'h00);
        check("rst_mid_zero",  32'(bus.zero), 32'd1);
        check("post_rst_count", 32'(bus.count), 32'd1);

        drive(1'b0, 3'b000, 8'h00, 8'h00, 1'b0, 1'b0);
        step();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/logic_unit_acc.md
LOGIC_UNIT_ACC -- requirements
Module: logic_unit_acc

Interface
- REQ-001 Parameter WIDTH, default 8, sets operand and result width in bits.
- REQ-002 Parameter CNT_W, default 4, sets accumulate-counter width in bits.
- REQ-003 Clocking and reset: one clock, clk; reset is synchronous and active-high, rst.
- REQ-004 Port clk  input  1  rising-edge clock.
- REQ-005 Port rst  input  1  synchronous active-high reset.
- REQ-006 Port in_valid  input  1  operands valid.
- REQ-007 Port in_ready  output  1  block can accept operands.
- REQ-008 Port a  input  WIDTH  first operand.
- REQ-009 Port b  input  WIDTH  second operand; ignored in accumulate mode.
- REQ-010 Port op  input  3  operation select.
- REQ-011 Port acc_mode  input  1  1 = accumulate, 0 = single-shot.
- REQ-012 Port clear  input  1  synchronous clear of accumulator and counter.
- REQ-013 Port out_valid  output  1  result register holds unconsumed data.
- REQ-014 Port out_ready  input  1  consumer accepts result.
- REQ-015 Port result  output  WIDTH  registered result.
- REQ-016 Port zero  output  1  result equals 0.
- REQ-017 Port parity  output  1  XOR-reduction of result.
- REQ-018 Port count  output  CNT_W  accepted accumulate operations since clear or reset.
- REQ-019 Port count_sat  output  1  count is at its maximum value.

Function
- REQ-020 The op encoding SHALL be: 000 OR, 001 NOR, 010 XOR, 011 XNOR, 100 AND, 101 NAND, 110 NOT x, 111 PASS x. Here x is the first operand, and op[1:0] under op[2]=0 keeps the legacy 2-bit key mapping.
- REQ-021 An input transfer SHALL occur when in_valid && in_ready are both high on a rising clk edge.
- REQ-022 in_ready SHALL equal (!out_valid || out_ready) && !rst, so a new transfer can be accepted in the same cycle the held result drains.
- REQ-023 Single-shot transfer: result SHALL be loaded with f(a, b), and the accumulator SHALL be unchanged.
- REQ-024 Accumulate transfer: the accumulator and result SHALL both be loaded with f(acc, a), and count SHALL increment.
- REQ-025 Latency SHALL be 1 cycle: out_valid rises on the edge that performs the transfer.
- REQ-026 The output FSM SHALL have two states. EMPTY (out_valid=0) goes to FULL on a transfer. FULL goes to EMPTY on out_ready without a transfer. FULL stays FULL, with a new result, when out_ready and a transfer occur together.
- REQ-027 While out_valid=1 && out_ready=0, result, zero and parity SHALL remain stable.
- REQ-028 zero and parity SHALL be registered on the same edge as result and derived from the new result value.
- REQ-029 clear SHALL set accumulator and count to 0 on the next edge and SHALL NOT affect out_valid or result.
- REQ-030 If clear coincides with an accumulate transfer, the operation SHALL use acc=0, and count SHALL become 1.
- REQ-031 count SHALL saturate at 2^CNT_W-1 without wrapping; count_sat SHALL be high exactly when count is at that maximum.
- REQ-032 All arithmetic SHALL be bitwise on WIDTH bits, with no carries or truncation.

Reset
- REQ-033 When rst is high on an edge, out_valid, result, zero, count, count_sat and the accumulator SHALL all become 0, and parity SHALL become 0.
- REQ-034 Reset SHALL take precedence over any transfer, clear or drain in the same cycle. A result pending at reset SHALL be discarded.
- REQ-035 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Verification (WIDTH=8, CNT_W=4)
- REQ-036 Single-shot with a=0xA5, b=0x0F: op=000 -> 0xAF; 001 -> 0x50; 010 -> 0xAA; 011 -> 0x55. Each result appears one cycle after its transfer.
- REQ-037 op=100 with a=0xF0, b=0x0F -> result 0x00, zero=1, parity=0. op=101 on the same operands -> 0xFF, zero=0, parity=0.
- REQ-038 After clear, acc_mode=1, op=010, a=0x01, 0x02, 0x04 -> results 0x01, 0x03, 0x07 and count=3.
- REQ-039 Backpressure: with out_ready=0, transfer 0x11 and then present 0x22 -> in_ready=0 and result held at 0x11. Raising out_ready -> 0x22 accepted that cycle and result becomes 0x22.
- REQ-040 With acc=0xFF, clear asserted together with an accumulate transfer of op=000, a=0x10 -> result 0x10 and count=1.
- REQ-041 Saturation: 17 accumulate transfers -> count=15 and count_sat=1. Next, reset asserted mid-stream with out_valid=1 -> next cycle out_valid=0, result=0x00, count=0, and the accumulator reads 0.
